// File: rtl/line_buffer_ctrl.sv
// Sequencing controller for a KxK sliding-window line buffer: clears the line FIFOs, gates pixel shifts and flags complete windows.
// Optional LINE_BUFFER_CTRL_CFG_CHECK_EN adds err_o and rejects frames whose row length or row count is below KERNEL.
module line_buffer_ctrl #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int KERNEL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [LEN_W-1:0] cfg_row_length_i,
  input  logic [LEN_W-1:0] cfg_num_rows_i,
  input  logic             pix_valid_i,
  output logic             pix_ready_o,
  output logic             shifting_o,
  output logic             fifo_reset_o,
  output logic [LEN_W-1:0] row_length_o,
  output logic             window_valid_o,
  output logic             busy_o,
  output logic             done_o,
`ifdef LINE_BUFFER_CTRL_CFG_CHECK_EN
  output logic             err_o,
`endif
  output logic [2:0]       state_o
);

  // Pixel handshake: a pixel moves when pix_valid_i and pix_ready_o are both
  // high on a rising edge; pix_valid_i may drop at any time and nothing times out.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FILL  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [LEN_W-1:0] K_LEN  = LEN_W'(KERNEL);
  localparam logic [LEN_W-1:0] K_LAST = LEN_W'(KERNEL - 1);

  if (KERNEL < 2 || DATA_W < 1) begin : g_bad_param
    $error("line_buffer_ctrl: KERNEL must be >= 2 and DATA_W >= 1");
  end

  state_t           state;
  logic [LEN_W-1:0] num_rows;
  logic [LEN_W-1:0] col_cnt;
  logic [LEN_W-1:0] row_cnt;
  logic             win_hit;
  logic             last_pix;

  // Abort and reset both veto a shift in the cycle they are asserted.
  assign shifting_o = pix_valid_i & pix_ready_o & ~abort_i & ~rst;
  assign win_hit    = (row_cnt >= K_LAST) && (col_cnt >= K_LAST);
  assign last_pix   = (row_cnt == num_rows - 1'b1) && (col_cnt == row_length_o - 1'b1);
  assign state_o    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      col_cnt        <= '0;
      row_cnt        <= '0;
      num_rows       <= '0;
      row_length_o   <= '0;
      fifo_reset_o   <= 1'b1;
      pix_ready_o    <= 1'b0;
      window_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
`ifdef LINE_BUFFER_CTRL_CFG_CHECK_EN
      err_o          <= 1'b0;
`endif
    end else begin
      window_valid_o <= 1'b0;
      done_o         <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
`ifdef LINE_BUFFER_CTRL_CFG_CHECK_EN
            if (cfg_row_length_i < K_LEN || cfg_num_rows_i < K_LEN) begin
              err_o <= 1'b1;
            end else begin
              err_o  <= 1'b0;
              state  <= CLEAR;
              busy_o <= 1'b1;
            end
`else
            state  <= CLEAR;
            busy_o <= 1'b1;
`endif
          end
        end
        CLEAR: begin
          if (abort_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            row_length_o <= cfg_row_length_i;
            num_rows     <= cfg_num_rows_i;
            col_cnt      <= '0;
            row_cnt      <= '0;
            fifo_reset_o <= 1'b0;
            pix_ready_o  <= 1'b1;
            state        <= FILL;
          end
        end
        FILL, RUN: begin
          if (abort_i) begin
            state        <= IDLE;
            fifo_reset_o <= 1'b1;
            pix_ready_o  <= 1'b0;
            busy_o       <= 1'b0;
          end else if (shifting_o) begin
            window_valid_o <= win_hit;
            if (col_cnt == row_length_o - 1'b1) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
            if (last_pix) begin
              state       <= DONE;
              pix_ready_o <= 1'b0;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
            end else if (state == FILL && win_hit) begin
              state <= RUN;
            end
          end
        end
        DONE: begin
          state        <= IDLE;
          fifo_reset_o <= 1'b1;
        end
        default: begin
          state        <= IDLE;
          fifo_reset_o <= 1'b1;
          pix_ready_o  <= 1'b0;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/line_buffer_ctrl.md
LINE_BUFFER_CTRL -- requirements
Module: line_buffer_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, pixel width (sideband only; controller does not store pixels).
REQ-002 Parameter LEN_W, default 8, width of row-length and row-count configuration.
REQ-003 Parameter KERNEL, default 3, window height/width; line FIFO chain depth = KERNEL-1.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start_i  in  1  begin one frame; sampled in IDLE only.
REQ-007 abort_i  in  1  terminate frame immediately.
REQ-008 cfg_row_length_i  in  LEN_W  pixels per row (N).
REQ-009 cfg_num_rows_i  in  LEN_W  rows per frame (R).
REQ-010 pix_valid_i  in  1  upstream pixel valid.
REQ-011 pix_ready_o  out  1  controller accepts pixel; accept = pix_valid_i & pix_ready_o.
REQ-012 shifting_o  out  1  shift enable to every line FIFO; combinational, equals accept.
REQ-013 fifo_reset_o  out  1  clear to every line FIFO.
REQ-014 row_length_o  out  LEN_W  latched N driven to line FIFOs.
REQ-015 window_valid_o  out  1  KxK window at FIFO taps is complete.
REQ-016 busy_o  out  1  high in CLEAR, FILL, RUN.
REQ-017 done_o  out  1  one-cycle frame-complete pulse.

Function
REQ-018 FSM states IDLE, CLEAR, FILL, RUN, DONE; all outputs except shifting_o registered/state-decoded.
REQ-019 IDLE: fifo_reset_o=1, pix_ready_o=0; start_i -> CLEAR next cycle.
REQ-020 CLEAR: exactly one cycle; latch N and R into row_length_o/internal regs; fifo_reset_o=1; zero col/row counters; -> FILL.
REQ-021 FILL and RUN: fifo_reset_o=0, pix_ready_o=1; config inputs ignored until next CLEAR.
REQ-022 col_cnt increments on accept, wraps N-1 -> 0; row_cnt increments on that wrap.
REQ-023 window_valid_o=1 in the cycle after an accept whose (row_cnt>=KERNEL-1 and col_cnt>=KERNEL-1); else 0.
REQ-024 FILL -> RUN on the first accept satisfying REQ-023.
REQ-025 Accept at row_cnt=R-1, col_cnt=N-1 -> DONE next cycle; pix_ready_o=0 from that cycle.
REQ-026 DONE: one cycle, done_o=1, -> IDLE.
REQ-027 Windows per frame = (R-KERNEL+1)*(N-KERNEL+1); total accepts = R*N.
REQ-028 abort_i in CLEAR/FILL/RUN -> IDLE next cycle, no done_o; abort wins over simultaneous last-pixel accept; shifting_o forced 0 that cycle.
REQ-029 abort_i in IDLE/DONE ignored; start_i outside IDLE ignored.
REQ-030 pix_valid_i low stalls counters and FSM; no timeout.

Reset
REQ-031 rst in any state -> IDLE next edge, counters 0, overrides start_i/abort_i.
REQ-032 Reset values: fifo_reset_o=1, row_length_o=0, pix_ready_o=0, window_valid_o=0, busy_o=0, done_o=0.

Configuration
REQ-033 Macro LINE_BUFFER_CTRL_CFG_CHECK_EN adds output port err_o (1 bit).
REQ-034 With macro: start_i with N<KERNEL or R<KERNEL stays in IDLE and sets err_o; err_o sticky until valid start_i or rst.
REQ-035 Without macro: no err_o port, config unchecked; illegal config yields zero windows but frame still completes per REQ-025.

Verification
REQ-036 N=10, R=5, KERNEL=3, pix_valid_i held 1 -> fifo_reset_o falls 2 cycles after start, first window_valid_o after 23rd accept, 24 windows total, done_o 1 cycle after 50th accept.
REQ-037 Same config, pix_valid_i toggling 1/0 -> identical 24 windows and 50 shifts, shifting_o never high while pix_valid_i low.
REQ-038 abort_i at 30th accept -> IDLE next cycle, fifo_reset_o=1, no done_o; new start completes full 50-pixel frame.
REQ-039 rst during RUN -> all outputs at REQ-032 values next cycle; start_i in same cycle as rst ignored.
REQ-040 Macro defined, N=2, start -> stays IDLE, err_o=1; then N=10 start -> err_o=0, normal frame.
